// File: rtl/id_ex_ctrl_stage_pkg.sv
// Shared definitions for the ID/EX control stage: default widths, NOP encoding,
// bubble-sequencer state encoding and control-bundle width.
package id_ex_ctrl_stage_pkg;
  localparam int ALUOP_W_DEF = 5;
  localparam logic [31:0] ALUOP_NOP = '0;

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} bubState_e;

  // Six single-bit controls, the ALU op and the valid bit.
  function automatic int ctrlWidth(int aluopW);
    return 6 + aluopW + 1;
  endfunction
endpackage

// File: rtl/id_ex_ctrl_stage_bubble_seq.sv
// Bubble sequencer: RUN/BUBBLE FSM, remaining-bubble counter, upstream stall
// and a saturating count of every bubble written into the stage register.
module bubble_seq
  import id_ex_ctrl_stage_pkg::*;
#(
  parameter int MAX_BUB = 3,
  parameter int LEN_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hold,
  input  logic             flush,
  input  logic             bubReq,
  input  logic [LEN_W-1:0] bubLen,
  output logic             injBub,
  output logic             upStall,
  output logic             bubActive,
  output logic [CNT_W-1:0] bubCnt
);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BUB);

  bubState_e        state;
  logic [LEN_W-1:0] remain;
  logic [LEN_W-1:0] reqLen;
  logic             startSeq;
  logic             bubWrite;

  assign reqLen    = (bubLen > MAX_L) ? MAX_L : bubLen;
  assign startSeq  = (state == RUN) && bubReq && (bubLen != '0);
  assign injBub    = startSeq || (state == BUBBLE);
  assign upStall   = injBub && !flush;
  assign bubActive = (state == BUBBLE);
  // A flush writes a bubble even on a held edge; injected bubbles need a free edge.
  assign bubWrite  = flush || (!hold && injBub);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= RUN;
      remain <= '0;
    end else if (flush) begin
      state  <= RUN;
      remain <= '0;
    end else if (!hold) begin
      case (state)
        RUN: if (startSeq) begin
          remain <= reqLen - 1'b1;
          state  <= (reqLen > 1) ? BUBBLE : RUN;
        end
        BUBBLE: begin
          remain <= (remain == '0) ? '0 : remain - 1'b1;
          if (remain <= 1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         bubCnt <= '0;
    else if (bubWrite && bubCnt != '1) bubCnt <= bubCnt + 1'b1;
  end
endmodule

// File: rtl/id_ex_ctrl_stage.sv
// Registered ID/EX control-bundle stage with flush, hold and multi-cycle
// bubble injection; priority flush > hold > bubble > normal load.
module id_ex_ctrl_stage
  import id_ex_ctrl_stage_pkg::*;
#(
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int MAX_BUB = 3,
  parameter int LEN_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_regwrite,
  input  logic               in_memtoreg,
  input  logic               in_memwrite,
  input  logic               in_memread,
  input  logic               in_branch,
  input  logic               in_alusrc,
  input  logic [ALUOP_W-1:0] in_aluop,
  input  logic               in_valid,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic               bub_req_i,
  input  logic [LEN_W-1:0]   bub_len_i,
  output logic               out_regwrite,
  output logic               out_memtoreg,
  output logic               out_memwrite,
  output logic               out_memread,
  output logic               out_branch,
  output logic               out_alusrc,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic               out_valid,
  output logic               up_stall_o,
  output logic               bub_active_o,
  output logic [CNT_W-1:0]   bub_cnt_o
);
  localparam int CTRL_W = ctrlWidth(ALUOP_W);
  localparam logic [CTRL_W-1:0] BUB_BUNDLE = {6'b0, ALUOP_NOP[ALUOP_W-1:0], 1'b0};

  logic [CTRL_W-1:0] inBundle, stageReg;
  logic              injBub;

  assign inBundle = {in_regwrite, in_memtoreg, in_memwrite, in_memread,
                     in_branch, in_alusrc, in_aluop, in_valid};

  bubble_seq #(.MAX_BUB(MAX_BUB), .LEN_W(LEN_W), .CNT_W(CNT_W)) uSeq (
    .clk       (clk),
    .rstn      (rstn),
    .hold      (hold_i),
    .flush     (flush_i),
    .bubReq    (bub_req_i),
    .bubLen    (bub_len_i),
    .injBub    (injBub),
    .upStall   (up_stall_o),
    .bubActive (bub_active_o),
    .bubCnt    (bub_cnt_o)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        stageReg <= '0;
    else if (flush_i) stageReg <= BUB_BUNDLE;
    else if (hold_i)  stageReg <= stageReg;
    else if (injBub)  stageReg <= BUB_BUNDLE;
    else              stageReg <= inBundle;
  end

  assign {out_regwrite, out_memtoreg, out_memwrite, out_memread,
          out_branch, out_alusrc, out_aluop, out_valid} = stageReg;
endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed bench for id_ex_ctrl_stage built with MAX_BUB=2, CNT_W=3 so clamping
// and counter saturation are reachable with short vectors.
module tb_id_ex_ctrl_stage;
  localparam int ALUOP_W = 5;
  localparam int LEN_W   = 2;
  localparam int CNT_W   = 3;

  logic clk = 1'b0;
  logic rstn;
  logic in_regwrite, in_memtoreg, in_memwrite, in_memread, in_branch, in_alusrc;
  logic [ALUOP_W-1:0] in_aluop;
  logic in_valid, hold_i, flush_i, bub_req_i;
  logic [LEN_W-1:0] bub_len_i;
  logic out_regwrite, out_memtoreg, out_memwrite, out_memread, out_branch, out_alusrc;
  logic [ALUOP_W-1:0] out_aluop;
  logic out_valid, up_stall_o, bub_active_o;
  logic [CNT_W-1:0] bub_cnt_o;

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  id_ex_ctrl_stage #(.ALUOP_W(ALUOP_W), .MAX_BUB(2), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_memwrite(in_memwrite),
    .in_memread(in_memread), .in_branch(in_branch), .in_alusrc(in_alusrc),
    .in_aluop(in_aluop), .in_valid(in_valid),
    .hold_i(hold_i), .flush_i(flush_i), .bub_req_i(bub_req_i), .bub_len_i(bub_len_i),
    .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg), .out_memwrite(out_memwrite),
    .out_memread(out_memread), .out_branch(out_branch), .out_alusrc(out_alusrc),
    .out_aluop(out_aluop), .out_valid(out_valid),
    .up_stall_o(up_stall_o), .bub_active_o(bub_active_o), .bub_cnt_o(bub_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the registered bundle and sequencer state in one go.
  task automatic chkOut(input string tag, input logic [ALUOP_W-1:0] op, input logic vld,
                        input logic act, input logic [CNT_W-1:0] cnt);
    chk({tag, ".aluop"}, 32'(out_aluop), 32'(op));
    chk({tag, ".valid"}, 32'(out_valid), 32'(vld));
    chk({tag, ".active"}, 32'(bub_active_o), 32'(act));
    chk({tag, ".cnt"}, 32'(bub_cnt_o), 32'(cnt));
  endtask

  initial begin
    rstn = 1'b0;
    {in_regwrite, in_memtoreg, in_memwrite, in_memread, in_branch, in_alusrc} = '0;
    in_aluop = '0; in_valid = 1'b0;
    hold_i = 1'b0; flush_i = 1'b0; bub_req_i = 1'b0; bub_len_i = '0;
    step(); step();
    chkOut("reset", 5'h00, 1'b0, 1'b0, 3'd0);
    chk("reset.regwrite", 32'(out_regwrite), 32'd0);
    chk("reset.stall", 32'(up_stall_o), 32'd0);

    // Normal load after reset release
    rstn = 1'b1; in_valid = 1'b1; in_aluop = 5'h0A; in_regwrite = 1'b1; in_memread = 1'b1;
    step();
    chkOut("load", 5'h0A, 1'b1, 1'b0, 3'd0);
    chk("load.regwrite", 32'(out_regwrite), 32'd1);
    chk("load.memread", 32'(out_memread), 32'd1);

    // Two-bubble request; the held instruction lands on the third edge
    in_aluop = 5'h03; in_memread = 1'b0; bub_req_i = 1'b1; bub_len_i = 2'd2;
    #1 chk("req2.stall0", 32'(up_stall_o), 32'd1);
    step();
    chkOut("req2.b1", 5'h00, 1'b0, 1'b1, 3'd1);
    chk("req2.b1.regwrite", 32'(out_regwrite), 32'd0);
    bub_req_i = 1'b0;
    #1 chk("req2.stall1", 32'(up_stall_o), 32'd1);
    step();
    chkOut("req2.b2", 5'h00, 1'b0, 1'b0, 3'd2);
    chk("req2.stall2", 32'(up_stall_o), 32'd0);
    step();
    chkOut("req2.ld", 5'h03, 1'b1, 1'b0, 3'd2);

    // Length 3 clamps to MAX_BUB=2
    in_aluop = 5'h07; bub_req_i = 1'b1; bub_len_i = 2'd3;
    step();
    chkOut("clamp.b1", 5'h00, 1'b0, 1'b1, 3'd3);
    bub_req_i = 1'b0;
    step();
    chkOut("clamp.b2", 5'h00, 1'b0, 1'b0, 3'd4);
    step();
    chkOut("clamp.ld", 5'h07, 1'b1, 1'b0, 3'd4);

    // Zero-length request is ignored
    in_aluop = 5'h09; bub_req_i = 1'b1; bub_len_i = 2'd0;
    #1 chk("len0.stall", 32'(up_stall_o), 32'd0);
    step();
    chkOut("len0.ld", 5'h09, 1'b1, 1'b0, 3'd4);

    // Hold for two edges mid-sequence
    in_aluop = 5'h0C; bub_req_i = 1'b1; bub_len_i = 2'd2;
    step();
    chkOut("hold.b1", 5'h00, 1'b0, 1'b1, 3'd5);
    bub_req_i = 1'b0; hold_i = 1'b1; in_aluop = 5'h1F;
    step(); step();
    chkOut("hold.frozen", 5'h00, 1'b0, 1'b1, 3'd5);
    chk("hold.stall", 32'(up_stall_o), 32'd1);
    hold_i = 1'b0; in_aluop = 5'h0C;
    step();
    chkOut("hold.b2", 5'h00, 1'b0, 1'b0, 3'd6);
    step();
    chkOut("hold.ld", 5'h0C, 1'b1, 1'b0, 3'd6);

    // Hold in RUN freezes a loaded instruction
    hold_i = 1'b1; in_aluop = 5'h1E;
    step();
    chkOut("holdrun", 5'h0C, 1'b1, 1'b0, 3'd6);
    hold_i = 1'b0;

    // Start a sequence, then assert reset asynchronously mid-cycle
    in_aluop = 5'h11; bub_req_i = 1'b1; bub_len_i = 2'd2;
    step();
    chkOut("pre_rst", 5'h00, 1'b0, 1'b1, 3'd7);
    rstn = 1'b0;
    #1;
    chkOut("midrst", 5'h00, 1'b0, 1'b0, 3'd0);
    rstn = 1'b1; bub_req_i = 1'b0; in_aluop = 5'h04;
    #1 chk("midrst.stall", 32'(up_stall_o), 32'd0);
    step();
    chkOut("postrst.ld", 5'h04, 1'b1, 1'b0, 3'd0);

    // Flush with hold during BUBBLE aborts the sequence
    bub_req_i = 1'b1; bub_len_i = 2'd2;
    step();
    chkOut("fl.b1", 5'h00, 1'b0, 1'b1, 3'd1);
    bub_req_i = 1'b0; flush_i = 1'b1; hold_i = 1'b1; in_aluop = 5'h15;
    #1 chk("fl.stall", 32'(up_stall_o), 32'd0);
    step();
    chkOut("fl.after", 5'h00, 1'b0, 1'b0, 3'd2);
    flush_i = 1'b0; hold_i = 1'b0;
    #1 chk("fl.stall_next", 32'(up_stall_o), 32'd0);
    step();
    chkOut("fl.ld", 5'h15, 1'b1, 1'b0, 3'd2);

    // Nine flushes saturate the 3-bit counter at 7
    flush_i = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chkOut("sat", 5'h00, 1'b0, 1'b0, 3'd7);
    flush_i = 1'b0; in_aluop = 5'h02;
    step();
    chkOut("sat.ld", 5'h02, 1'b1, 1'b0, 3'd7);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
